// File: rtl/rgb_link_pkg.sv
// Shared constants, types and helpers for the RGB display-link receiver.
// Frame layout: elevator floor nibbles sit at fixed bit offsets in a 24-bit word.
package rgb_link_pkg;

   localparam int FRAME_BITS = 24;
   localparam int E1_LSB     = 20;
   localparam int E2_LSB     = 8;

   typedef logic [3:0] floor_t;

   typedef enum logic {
      WAIT_SYNC = 1'b0,
      RUN       = 1'b1
   } rx_state_t;

   // 0000 is rejected: an elevator must always be on exactly one floor.
   function automatic logic is_onehot4(input floor_t f);
      return (f != 4'd0) && ((f & (f - 4'd1)) == 4'd0);
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for asynchronous link pins, with an optional rise pulse
// produced by comparing the synchronised level against one history flop.
module sync_edge #(
   parameter int STAGES   = 2,
   parameter int WIDTH    = 1,
   parameter bit HAS_RISE = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] rise
);

   logic [STAGES-1:0][WIDTH-1:0] chain;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], din};
      end
   end

   assign level = chain[STAGES-1];

   generate
      if (HAS_RISE) begin : g_rise
         logic [WIDTH-1:0] hist;
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               hist <= '0;
            end else begin
               hist <= level;
            end
         end
         assign rise = level & ~hist;
      end else begin : g_no_rise
         assign rise = '0;
      end
   endgenerate

endmodule

// File: rtl/rgb_frame_receiver.sv
// Rebuilds 24-bit frames from the 74HC595-style serial link and decodes the two
// elevator floor nibbles; flags malformed frames and wrong shift counts.
module rgb_frame_receiver
   import rgb_link_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  SH_CP,
   input  logic                  ST_CP,
   input  logic                  MR,
   input  logic                  OE,
   input  logic                  data,
   output logic [FRAME_BITS-1:0] frame,
   output floor_t                elevator1,
   output floor_t                elevator2,
   output logic                  frame_valid,
   output logic                  decode_err,
   output logic                  len_err,
   output logic                  display_on,
   output logic                  synced,
   output rx_state_t             rx_state
);

   logic                  sh_rise, st_rise;
   logic                  data_s, mr_s, oe_s;
   logic                  unused_sh_level, unused_st_level;
   logic [2:0]            unused_rise;
   logic [FRAME_BITS-1:0] sreg;
   logic [4:0]            bit_cnt;
   rx_state_t             state, next_state;
   logic                  latch_run;

   sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(1), .HAS_RISE(1'b1)) u_sh (
      .clk(clk), .reset(reset), .din(SH_CP), .level(unused_sh_level), .rise(sh_rise)
   );

   sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(1), .HAS_RISE(1'b1)) u_st (
      .clk(clk), .reset(reset), .din(ST_CP), .level(unused_st_level), .rise(st_rise)
   );

   // data shares the SH_CP depth so the bit is sampled on the aligned edge.
   sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(3), .HAS_RISE(1'b0)) u_lvl (
      .clk(clk), .reset(reset), .din({data, MR, OE}),
      .level({data_s, mr_s, oe_s}), .rise(unused_rise)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= WAIT_SYNC;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      latch_run  = 1'b0;
      case (state)
         WAIT_SYNC: if (st_rise) next_state = RUN;
         RUN:       latch_run = st_rise;
      endcase
   end

   assign rx_state = state;
   assign synced   = (state == RUN);

   // A latch coinciding with a shift restarts the count at 1 for that shift.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sreg    <= '0;
         bit_cnt <= '0;
      end else if (!mr_s) begin
         sreg    <= '0;
         bit_cnt <= '0;
      end else begin
         if (sh_rise) begin
            sreg <= {data_s, sreg[FRAME_BITS-1:1]};
         end
         if (st_rise) begin
            bit_cnt <= sh_rise ? 5'd1 : 5'd0;
         end else if (sh_rise && (bit_cnt != 5'd31)) begin
            bit_cnt <= bit_cnt + 5'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame       <= '0;
         elevator1   <= '0;
         elevator2   <= '0;
         frame_valid <= 1'b0;
         decode_err  <= 1'b0;
         len_err     <= 1'b0;
         display_on  <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         display_on  <= ~oe_s;
         if (latch_run) begin
            frame       <= sreg;
            elevator1   <= sreg[E1_LSB +: 4];
            elevator2   <= sreg[E2_LSB +: 4];
            decode_err  <= !is_onehot4(sreg[E1_LSB +: 4]) || !is_onehot4(sreg[E2_LSB +: 4]);
            len_err     <= (bit_cnt != 5'(FRAME_BITS));
            frame_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_rgb_frame_receiver.sv
// Self-checking bench for rgb_frame_receiver: drives the serial link slowly,
// tracks received bits in a queue-based model and compares every latched frame.
module tb_rgb_frame_receiver;
   import rgb_link_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        SH_CP = 1'b0, ST_CP = 1'b0, MR = 1'b1, OE = 1'b1, data = 1'b0;
   logic [23:0] frame;
   floor_t      elevator1, elevator2;
   logic        frame_valid, decode_err, len_err, display_on, synced;
   rx_state_t   rx_state;

   int errors = 0;
   int checks = 0;

   // Reference model: bits received since the last clear, newest last.
   bit          hist_q[$];
   int          m_cnt = 0;
   bit          m_synced = 1'b0;
   logic [23:0] m_frame = '0;
   logic [3:0]  m_e1 = '0, m_e2 = '0;
   bit          m_derr = 1'b0, m_lerr = 1'b0;

   always #5 clk = ~clk;

   rgb_frame_receiver #(.SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .SH_CP(SH_CP), .ST_CP(ST_CP), .MR(MR), .OE(OE),
      .data(data), .frame(frame), .elevator1(elevator1), .elevator2(elevator2),
      .frame_valid(frame_valid), .decode_err(decode_err), .len_err(len_err),
      .display_on(display_on), .synced(synced), .rx_state(rx_state)
   );

   function automatic logic [23:0] model_frame();
      logic [23:0] f = '0;
      int n = hist_q.size();
      for (int i = 0; i < 24; i++) if (n - 24 + i >= 0) f[i] = hist_q[n - 24 + i];
      return f;
   endfunction

   function automatic bit onehot_ok(input logic [3:0] n);
      return $countones(n) == 1;
   endfunction

   task automatic model_push(input bit b);
      if (MR) begin
         hist_q.push_back(b);
         if (hist_q.size() > 24) void'(hist_q.pop_front());
         if (m_cnt < 31) m_cnt++;
      end
   endtask

   task automatic model_latch();
      if (!m_synced) begin
         m_synced = 1'b1;
      end else begin
         m_frame = model_frame();
         m_e1    = m_frame[23:20];
         m_e2    = m_frame[11:8];
         m_derr  = !(onehot_ok(m_e1) && onehot_ok(m_e2));
         m_lerr  = (m_cnt != 24);
      end
      m_cnt = 0;
   endtask

   task automatic model_reset();
      hist_q.delete();
      m_cnt = 0; m_synced = 1'b0; m_frame = '0; m_e1 = '0; m_e2 = '0;
      m_derr = 1'b0; m_lerr = 1'b0;
   endtask

   task automatic shift_bit(input bit b);
      @(negedge clk); data = b;
      repeat (3) @(negedge clk);
      SH_CP = 1'b1; model_push(b);
      repeat (4) @(negedge clk);
      SH_CP = 1'b0;
   endtask

   task automatic send_bits(input logic [31:0] v, input int n);
      for (int i = 0; i < n; i++) shift_bit(v[i]);
   endtask

   // first = clk edges from pin rise to first frame_valid (-1 if none); width = pulse length.
   task automatic watch_valid(output int first, output int width);
      first = -1; width = 0;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk); #1;
         if (frame_valid) begin
            width++;
            if (first < 0) first = c;
         end
      end
   endtask

   task automatic do_latch(output int first, output int width);
      @(negedge clk); ST_CP = 1'b1;
      model_latch();
      watch_valid(first, width);
      @(negedge clk); ST_CP = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk); #1;
      checks++; if (frame !== 24'h0) begin errors++; $display("FAIL reset_frame: got %h want 000000", frame); end
      checks++; if ({elevator1, elevator2} !== 8'h0) begin errors++; $display("FAIL reset_elev: got %b/%b want 0", elevator1, elevator2); end
      checks++; if ({frame_valid, decode_err, len_err} !== 3'b0) begin errors++; $display("FAIL reset_flags: got %b want 000", {frame_valid, decode_err, len_err}); end
      checks++; if ({display_on, synced} !== 2'b0) begin errors++; $display("FAIL reset_status: got %b want 00", {display_on, synced}); end
      @(negedge clk); reset = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_sync_and_first_frame();
      int first, width;
      send_bits(32'h100100, 24);
      do_latch(first, width);
      checks++; if (first != -1) begin errors++; $display("FAIL sync_no_valid: frame_valid at %0d want none", first); end
      checks++; if (synced !== 1'b1) begin errors++; $display("FAIL sync_flag: got %b want 1", synced); end
      send_bits(32'h800800, 24);
      do_latch(first, width);
      checks++; if (first != 3 || width != 1) begin errors++; $display("FAIL first_valid: at %0d width %0d want 3/1", first, width); end
      checks++; if (frame !== m_frame) begin errors++; $display("FAIL first_frame: got %h want %h", frame, m_frame); end
      checks++; if (elevator1 !== m_e1 || elevator2 !== m_e2) begin errors++; $display("FAIL first_elev: got %b/%b want %b/%b", elevator1, elevator2, m_e1, m_e2); end
      checks++; if (decode_err !== 1'b0 || len_err !== 1'b0) begin errors++; $display("FAIL first_err: got %b%b want 00", decode_err, len_err); end
   endtask

   task automatic test_latency_run();
      int first, width;
      OE = 1'b0;
      send_bits(32'h200400, 24);
      checks++; if (display_on !== 1'b1) begin errors++; $display("FAIL display_on: got %b want 1", display_on); end
      do_latch(first, width);
      checks++; if (first != 3) begin errors++; $display("FAIL latency: frame_valid at %0d want 3", first); end
      checks++; if (elevator1 !== 4'b0010 || elevator2 !== 4'b0100) begin errors++; $display("FAIL run_elev: got %b/%b want 0010/0100", elevator1, elevator2); end
      checks++; if (frame !== m_frame) begin errors++; $display("FAIL run_frame: got %h want %h", frame, m_frame); end
   endtask

   task automatic test_len_err();
      int first, width;
      send_bits(32'h0, 1);
      send_bits(32'h400100, 24);
      do_latch(first, width);
      checks++; if (len_err !== 1'b1 || m_lerr !== 1'b1) begin errors++; $display("FAIL len25: got %b want 1", len_err); end
      checks++; if (frame !== m_frame) begin errors++; $display("FAIL len25_frame: got %h want %h", frame, m_frame); end
      send_bits(32'h100200, 24);
      do_latch(first, width);
      checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL len_clear: got %b want 0", len_err); end
   endtask

   task automatic test_decode_err();
      int first, width;
      send_bits(32'h300000, 24);
      do_latch(first, width);
      checks++; if (decode_err !== 1'b1) begin errors++; $display("FAIL decode_err: got %b want 1", decode_err); end
      checks++; if (elevator1 !== 4'b0011 || elevator2 !== 4'b0000) begin errors++; $display("FAIL decode_elev: got %b/%b want 0011/0000", elevator1, elevator2); end
   endtask

   task automatic test_mr();
      int first, width;
      @(negedge clk); MR = 1'b0;
      hist_q.delete(); m_cnt = 0;
      repeat (5) @(negedge clk);
      send_bits(32'hFFFF_FFFF, 10);
      @(negedge clk); MR = 1'b1;
      repeat (5) @(negedge clk);
      do_latch(first, width);
      checks++; if (frame !== 24'h0) begin errors++; $display("FAIL mr_frame: got %h want 000000", frame); end
      checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL mr_len: got %b want 1", len_err); end
   endtask

   task automatic test_simultaneous();
      int first, width;
      logic [23:0] pre;
      send_bits(32'h810420, 24);
      pre = model_frame();
      @(negedge clk); data = 1'b1;
      repeat (3) @(negedge clk);
      SH_CP = 1'b1; ST_CP = 1'b1;
      model_latch(); model_push(1'b1);
      watch_valid(first, width);
      @(negedge clk); SH_CP = 1'b0; ST_CP = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (frame !== pre || pre !== 24'h810420) begin errors++; $display("FAIL simul_frame: got %h want %h", frame, pre); end
      checks++; if (first != 3) begin errors++; $display("FAIL simul_valid: at %0d want 3", first); end
      send_bits(32'h0, 23);
      do_latch(first, width);
      checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL simul_len: got %b want 0", len_err); end
      checks++; if (frame !== m_frame) begin errors++; $display("FAIL simul_next: got %h want %h", frame, m_frame); end
   endtask

   task automatic test_random();
      int first, width, n;
      logic [31:0] v;
      for (int it = 0; it < 8; it++) begin
         v = $urandom;
         v[23:20] = 4'b0001 << $urandom_range(0, 3);
         v[11:8]  = 4'b0001 << $urandom_range(0, 3);
         if ($urandom_range(0, 3) == 0) v[23:20] = 4'($urandom);
         if ($urandom_range(0, 3) == 0) v[11:8]  = 4'($urandom);
         n = ($urandom_range(0, 2) == 0) ? $urandom_range(23, 25) : 24;
         send_bits(v, n);
         do_latch(first, width);
         checks++; if (first != 3 || width != 1) begin errors++; $display("FAIL rand%0d_valid: at %0d width %0d want 3/1", it, first, width); end
         checks++; if (frame !== m_frame) begin errors++; $display("FAIL rand%0d_frame: got %h want %h", it, frame, m_frame); end
         checks++; if (elevator1 !== m_e1 || elevator2 !== m_e2) begin errors++; $display("FAIL rand%0d_elev: got %b/%b want %b/%b", it, elevator1, elevator2, m_e1, m_e2); end
         checks++; if (decode_err !== m_derr || len_err !== m_lerr) begin errors++; $display("FAIL rand%0d_err: got %b%b want %b%b", it, decode_err, len_err, m_derr, m_lerr); end
      end
   endtask

   task automatic test_reset_mid_frame();
      int first, width;
      send_bits(32'hABC, 12);
      @(negedge clk); reset = 1'b1;
      model_reset();
      #1;
      checks++; if ({frame, elevator1, elevator2} !== 32'h0) begin errors++; $display("FAIL midreset_data: got %h/%b/%b want 0", frame, elevator1, elevator2); end
      checks++; if ({frame_valid, decode_err, len_err, synced} !== 4'b0) begin errors++; $display("FAIL midreset_flags: got %b want 0000", {frame_valid, decode_err, len_err, synced}); end
      repeat (2) @(negedge clk); reset = 1'b0;
      repeat (4) @(negedge clk);
      do_latch(first, width);
      checks++; if (first != -1 || synced !== 1'b1) begin errors++; $display("FAIL midreset_sync: valid %0d synced %b want -1/1", first, synced); end
      send_bits(32'h5A5, 12);
      do_latch(first, width);
      checks++; if (frame !== m_frame || m_frame !== 24'h5A5000) begin errors++; $display("FAIL midreset_frame: got %h want %h", frame, m_frame); end
      checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL midreset_len: got %b want 1", len_err); end
   endtask

   initial begin
      test_reset();
      test_sync_and_first_frame();
      test_latency_run();
      test_len_err();
      test_decode_err();
      test_mr();
      test_simultaneous();
      test_random();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
